// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared scoreboard entry type and forwarding-select codes
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    // Widest register number an entry can hold; narrower numbers are zero-extended.
    localparam int SB_DST_W = 8;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic [SB_DST_W-1:0] dst;
        logic                is_load;
    } sb_entry_t;

    localparam int FWD_GPR = 0;
    localparam int FWD_EXE = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_if : ID-stage request / pipeline-control bundle for hazard_ctrl
// Revision : 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int DEPTH      = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_reg_write;
    logic [REG_ADDR_W-1:0] id_num_write;
    logic                  id_is_load;
    logic                  exe_branch_taken;
    logic                  ext_stall;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_exe_flush;
    logic [SEL_W-1:0]      fwd_a_sel;
    logic [SEL_W-1:0]      fwd_b_sel;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;
    logic [CNT_W-1:0]      retired;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
               id_num_write, id_is_load, exe_branch_taken, ext_stall,
        input  pc_en, if_id_en, if_id_flush, id_exe_flush, fwd_a_sel, fwd_b_sel,
               stall_cycles, flush_count, retired
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
               id_num_write, id_is_load, exe_branch_taken, ext_stall,
        output pc_en, if_id_en, if_id_flush, id_exe_flush, fwd_a_sel, fwd_b_sel,
               stall_cycles, flush_count, retired
    );

endinterface
`default_nettype wire

// File: rtl/sb_shift.sv
`default_nettype none
// ============================================================================
// sb_shift : DEPTH-entry in-flight write scoreboard (hold / bubble / async clear)
// Revision : 1.0
// ============================================================================
module sb_shift
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      hold,
    input  wire logic      bubble,
    input  wire sb_entry_t ins,
    output sb_entry_t      entries [DEPTH]
);

    sb_entry_t r_sb [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_sb[k] <= '0;
            end
        end else if (!hold) begin
            r_sb[0] <= bubble ? '0 : ins;
            for (int k = 1; k < DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

    assign entries = r_sb;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : forwarding selects, load-use stall, branch squash, perf counters
// Revision : 1.0
// ============================================================================
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  wire logic     clock,
    input  wire logic     reset,
    hazard_ctrl_if.slave  bus
);

    localparam int SEL_W = $clog2(DEPTH + 1);

    sb_entry_t        w_sb [DEPTH];
    sb_entry_t        w_ins;
    logic             w_load_use;
    logic             w_branch;
    logic             w_bubble;
    logic [SEL_W-1:0] w_fwd_a;
    logic [SEL_W-1:0] w_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_retired;

    function automatic logic hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] r);
        return e.valid && e.reg_write && (e.dst == SB_DST_W'(r)) && (r != '0);
    endfunction

    always_comb begin
        w_ins           = '0;
        w_ins.valid     = bus.id_valid;
        w_ins.reg_write = bus.id_reg_write;
        w_ins.dst       = SB_DST_W'(bus.id_num_write);
        w_ins.is_load   = bus.id_is_load;
    end

    assign w_load_use = bus.id_valid && w_sb[0].valid && w_sb[0].is_load &&
                        ((bus.id_uses_rs && hit(w_sb[0], bus.id_rs)) ||
                         (bus.id_uses_rt && hit(w_sb[0], bus.id_rt)));
    assign w_branch   = bus.exe_branch_taken && !bus.ext_stall;
    assign w_bubble   = w_branch || w_load_use || !bus.id_valid;

    // Scan from the oldest entry down so the youngest match wins; a load still
    // in EXE has no data yet and is left to the stall path.
    always_comb begin
        w_fwd_a = SEL_W'(FWD_GPR);
        w_fwd_b = SEL_W'(FWD_GPR);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (k != 0 || !w_sb[0].is_load) begin
                if (bus.id_uses_rs && hit(w_sb[k], bus.id_rs)) w_fwd_a = SEL_W'(k + 1);
                if (bus.id_uses_rt && hit(w_sb[k], bus.id_rt)) w_fwd_b = SEL_W'(k + 1);
            end
        end
    end

    always_comb begin
        bus.pc_en        = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_exe_flush = 1'b0;
        if (bus.ext_stall) begin
            bus.pc_en    = 1'b0;
            bus.if_id_en = 1'b0;
        end else if (w_branch) begin
            bus.if_id_flush  = 1'b1;
            bus.id_exe_flush = 1'b1;
        end else if (w_load_use) begin
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_exe_flush = 1'b1;
        end
    end

    sb_shift #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk     (clock),
        .rst     (reset),
        .hold    (bus.ext_stall),
        .bubble  (w_bubble),
        .ins     (w_ins),
        .entries (w_sb)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_retired   <= '0;
        end else if (!bus.ext_stall) begin
            if (w_load_use && !w_branch) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_branch)                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (w_sb[DEPTH-1].valid)     r_retired   <= r_retired + CNT_W'(1);
        end
    end

    assign bus.fwd_a_sel    = w_fwd_a;
    assign bus.fwd_b_sel    = w_fwd_b;
    assign bus.stall_cycles = r_stall_cnt;
    assign bus.flush_count  = r_flush_cnt;
    assign bus.retired      = r_retired;

endmodule
`default_nettype wire
